mem_responder: RTL and testbench
================================

# mem_responder

Synthesizable memory-side responder for the cache's memory port. It accepts word read and write requests from the cache's `o_mem_*` outputs, paces acceptance with a fixed issue interval, and returns read data after a fixed latency. It supports several reads in flight at once. It is used as the backing store under `cache` in simulation and FPGA bring-up, and can be preloaded with a program image.

## Interface
- `SIZE`, 16384: storage size in bytes. Must be a power of two and at least 4.
- `LATENCY`, 4: cycles from the request acceptance edge to the read response. Must be at least 1.
- `INTERVAL`, 2: minimum spacing in cycles between accepted requests. Must be at least 1.

- `i_clk`, input, 1: clock. All state updates on the rising edge.
- `i_rst_n`, input, 1: reset. Asynchronous assert, active-low.
- `o_ready`, output, 1: responder can accept a request this cycle.
- `i_addr`, input, 32: byte address. Bits [1:0] are ignored.
- `i_ren`, input, 1: read request.
- `i_wen`, input, 1: write request.
- `i_mask`, input, 4: byte-enable mask for writes. Bit k enables byte k (bits [8k+7:8k]).
- `i_wdata`, input, 32: write data.
- `o_valid`, output, 1: one-cycle read response strobe.
- `o_addr`, output, 32: address of the responding read, with bits [1:0] forced to 0.
- `o_rdata`, output, 32: read data. Meaningful only while `o_valid` is high.

## Operation
- Storage: SIZE/4 words, indexed by `i_addr[log2(SIZE)-1:2]`. Upper address bits are ignored, so addresses wrap modulo SIZE. The array is not cleared by reset and is preloadable by hex image.
- Acceptance: a request is accepted at a rising edge where `o_ready` and (`i_ren` or `i_wen`) are both high. If `o_ready` is low, requests have no effect and are not queued.
- Write: the masked bytes are committed at the acceptance edge. A write produces no response. A mask of 0000 is accepted but changes nothing.
- Read: the word is captured at the acceptance edge. A later write to the same word does not change the returned data.
  - The capture enters a delay pipeline of depth LATENCY. Each stage holds valid, address and data.
  - Maximum reads in flight: ceil(LATENCY/INTERVAL). No backpressure on the response side.
- `i_ren` and `i_wen` both high: handled as a write only. No read response is produced.
- Issue pacing:
  - A down-counter is loaded with INTERVAL-1 on each acceptance.
  - `o_ready` = (counter == 0), and the counter decrements while nonzero.
  - With INTERVAL=1, `o_ready` stays high continuously.
- States (ready / cooling) are implied by the counter. A separate FSM is not required.

## Timing
- Reset values: `o_ready`=0, `o_valid`=0, `o_addr`=0, `o_rdata`=0. The pipeline is emptied and the counter cleared.
- First edge after `i_rst_n` rises: `o_ready`=1 in the following cycle. The reset deassertion edge itself accepts nothing.
- Read accepted at edge N:
  - `o_valid` goes high after edge N+LATENCY, for exactly one cycle.
  - `o_addr` and `o_rdata` are registered and are held at their last values when `o_valid` is low.
- Accept at edge N: `o_ready` is low for cycles N+1 … N+INTERVAL-1 and high again after edge N+INTERVAL-1.
- Back-to-back reads at maximum rate return in order, spaced INTERVAL cycles apart.
- Reset mid-operation:
  - In-flight reads are dropped, and no `o_valid` appears after reset.
  - Writes already committed persist.
  - A write on the same edge that reset asserts is not committed.
- All outputs are driven from flops. There is no combinational path from inputs to outputs.

## Test plan
- Preload word 0x10 = 0x12345678. Read at 0x10 accepted at edge 0 (LATENCY=4, INTERVAL=2) -> `o_valid` for exactly one cycle after edge 4, `o_addr`=0x10, `o_rdata`=0x12345678. `o_ready` is low for one cycle after acceptance.
- Reads at 0x0, 0x4, 0x8 issued every cycle while request is held -> accepted at edges 0, 2, 4. Responses after edges 4, 6, 8 in order, with the preloaded data.
- Write 0xDEADBEEF mask 1111 to 0x20, then write 0xBEEF0000 mask 1100, then read 0x20 -> 0xBEEFBEEF. Write 0x0000CAFE mask 0011, then read -> 0xBEEFCAFE.
- Read 0x40 (old value 0xAAAAAAAA) accepted, then write 0x55555555 to 0x40 accepted two cycles later -> read response is 0xAAAAAAAA. A subsequent read returns 0x55555555.
- Address 0x4010 with SIZE=16384 -> aliases word 0x10. `i_ren` and `i_wen` both high -> write commits and `o_valid` never asserts.
- Reset asserted two cycles after a read is accepted -> all outputs 0 immediately, no `o_valid` afterwards. `o_ready`=1 one cycle after release. Preloaded and written contents are intact.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed backing store for the cache memory port: paced request
// acceptance, masked writes, and fixed-latency read responses with several reads in flight.
module mem_responder #(
  parameter int SIZE     = 16384,
  parameter int LATENCY  = 4,
  parameter int INTERVAL = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [3:0]  i_mask,
  input  logic [31:0] i_wdata,
  output logic        o_valid,
  output logic [31:0] o_addr,
  output logic [31:0] o_rdata
);

  localparam int WORDS = SIZE / 4;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [31:0]   mem [WORDS];
  logic [IW-1:0] idx;
  logic          accept;
  logic          wr_acc;
  logic          rd_acc;
  logic [CW-1:0] cnt;
  logic          unused_addr_lsb;

  logic          vld_p  [LATENCY];
  logic [31:0]   addr_p [LATENCY];
  logic [31:0]   data_p [LATENCY];

  // Upper address bits fall off the index, so the store wraps modulo SIZE.
  assign idx             = i_addr[IW+1:2] & IW'(WORDS - 1);
  assign accept          = o_ready & (i_ren | i_wen);
  assign wr_acc          = accept & i_wen;
  assign rd_acc          = accept & i_ren & ~i_wen;
  assign unused_addr_lsb = ^i_addr[1:0];

  // Issue pacing: o_ready is the registered form of (cnt == 0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      o_ready <= 1'b0;
    end else if (accept) begin
      cnt     <= CW'(INTERVAL - 1);
      o_ready <= (INTERVAL == 1);
    end else if (cnt != '0) begin
      cnt     <= cnt - 1'b1;
      o_ready <= (cnt == CW'(1));
    end else begin
      o_ready <= 1'b1;
    end
  end

  // Storage: masked byte writes; no reset so contents survive i_rst_n.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int k = 0; k < 4; k++) begin
        if (i_mask[k]) mem[idx][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  // Stage p0 captures the read; later stages only delay it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_acc;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (rd_acc) begin
      addr_p[0] <= {i_addr[31:2], 2'b00};
      data_p[0] <= mem[idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      addr_p[i] <= addr_p[i-1];
      data_p[i] <= data_p[i-1];
    end
  end

  // Response register: address/data hold their last values between strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_addr  <= '0;
      o_rdata <= '0;
    end else begin
      o_valid <= vld_p[LATENCY-1];
      if (vld_p[LATENCY-1]) begin
        o_addr  <= addr_p[LATENCY-1];
        o_rdata <= data_p[LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a behavioural memory model predicts
// acceptance, stored contents and response timing; a monitor checks every cycle.
module tb_mem_responder;

  localparam int SIZE     = 16384;
  localparam int LATENCY  = 4;
  localparam int INTERVAL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] wdata = '0;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_addr;
  logic [31:0] o_rdata;

  int ntests = 0;
  int nfail  = 0;

  mem_responder #(.SIZE(SIZE), .LATENCY(LATENCY), .INTERVAL(INTERVAL)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_ready (o_ready),
    .i_addr  (addr),
    .i_ren   (ren),
    .i_wen   (wen),
    .i_mask  (mask),
    .i_wdata (wdata),
    .o_valid (o_valid),
    .o_addr  (o_addr),
    .o_rdata (o_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [SIZE/4];
  int          edge_n   = 0;
  int          last_acc = -1000;
  bit          mdl_ready = 1'b0;
  int          n_acc    = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: ready is high unless an acceptance happened fewer than
  // INTERVAL-1 edges ago; reads return the word as it stood at acceptance.
  always @(posedge clk) begin
    edge_n++;
    if (rst_n) begin
      if (mdl_ready && (ren || wen)) begin
        int w;
        n_acc++;
        last_acc = edge_n;
        w = int'((addr % SIZE) / 4);
        if (wen) begin
          for (int k = 0; k < 4; k++)
            if (mask[k]) ref_mem[w][8*k +: 8] = wdata[8*k +: 8];
        end else begin
          exp_q.push_back('{edge_n + LATENCY, {addr[31:2], 2'b00}, ref_mem[w]});
        end
      end
      mdl_ready = (edge_n - last_acc) >= (INTERVAL - 1);
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    mdl_ready = 1'b0;
    last_acc  = -1000;
    last_addr = '0;
    last_data = '0;
  end

  // Monitor: compares whatever the DUT presents against the model's queue.
  always @(negedge clk) begin
    chk("ready", {31'd0, o_ready}, {31'd0, mdl_ready});
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL spurious_valid: got o_valid=1 addr %h, expected no response", o_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_edge", edge_n, mon_e.due);
        chk("resp_addr", o_addr, mon_e.addr);
        chk("resp_data", o_rdata, mon_e.data);
        last_addr = mon_e.addr;
        last_data = mon_e.data;
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
        mon_e = exp_q.pop_front();
        ntests++;
        nfail++;
        $display("FAIL missing_valid: got o_valid=0, expected response addr %h data %h", mon_e.addr, mon_e.data);
      end
      chk("hold_addr", o_addr, last_addr);
      chk("hold_data", o_rdata, last_data);
    end
  end

  // Drive a request and keep it asserted until the model sees it accepted.
  task automatic issue(input logic [31:0] a, input bit r, input bit w,
                       input logic [3:0] m, input logic [31:0] d);
    int start;
    int k;
    start = n_acc;
    k = 0;
    addr = a; ren = r; wen = w; mask = m; wdata = d;
    while (n_acc == start && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (n_acc == start) begin
      ntests++;
      nfail++;
      $display("FAIL accept_timeout: got no acceptance in %0d cycles, expected one for addr %h", k, a);
    end
  endtask

  task automatic idle(input int n);
    ren = 1'b0;
    wen = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    int op;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      if (i == 4)  v = 32'h1234_5678;
      if (i == 16) v = 32'hAAAA_AAAA;
      issue(32'(i * 4), 1'b0, 1'b1, 4'hF, v);
    end
    idle(LATENCY + 2);

    issue(32'h10, 1'b1, 1'b0, 4'h0, '0);
    idle(LATENCY + 2);
    issue(32'h0, 1'b1, 1'b0, 4'h0, '0);
    issue(32'h4, 1'b1, 1'b0, 4'h0, '0);
    issue(32'h8, 1'b1, 1'b0, 4'h0, '0);
    idle(LATENCY + 2);
    issue(32'h20, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    issue(32'h20, 1'b0, 1'b1, 4'b1100, 32'hBEEF_0000);
    issue(32'h20, 1'b1, 1'b0, 4'h0, '0);
    issue(32'h20, 1'b0, 1'b1, 4'b0011, 32'h0000_CAFE);
    issue(32'h20, 1'b1, 1'b0, 4'h0, '0);
    issue(32'h24, 1'b0, 1'b1, 4'b0000, 32'hFFFF_FFFF);
    issue(32'h24, 1'b1, 1'b0, 4'h0, '0);
    idle(LATENCY + 2);
    issue(32'h40, 1'b1, 1'b0, 4'h0, '0);
    issue(32'h40, 1'b0, 1'b1, 4'hF, 32'h5555_5555);
    issue(32'h40, 1'b1, 1'b0, 4'h0, '0);
    idle(LATENCY + 2);
    issue(32'h4012, 1'b1, 1'b0, 4'h0, '0);
    issue(32'h4010, 1'b1, 1'b1, 4'hF, 32'h0BAD_F00D);
    issue(32'h10, 1'b1, 1'b0, 4'h0, '0);
    idle(LATENCY + 2);

    for (int n = 0; n < 1500; n++) begin
      a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 9);
      issue(a, (op < 5) || (op == 9), op >= 5, 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end
    idle(LATENCY + 2);

    issue(32'h10, 1'b1, 1'b0, 4'h0, '0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_addr", o_addr, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(LATENCY + 2);
    for (int i = 0; i < 64; i++) issue(32'(i * 4), 1'b1, 1'b0, 4'h0, '0);
    idle(LATENCY + 4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
